pb_key_bridge: RTL and testbench

//  Parametrised successor to the fixed 4-way PicoBlaze input mux. A producer kcpsm3 (key-stream/PRNG) pushes key

---
 rtl/pb_key_bridge.sv | 154 +++++++++++++++
 tb/tb_pb_key_bridge.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pb_key_bridge.sv
// pb_key_bridge
//   Buffered bridge between a producer kcpsm3 (key stream) and a consumer
//   kcpsm3 (cipher). The producer pushes key bytes into a DEPTH-entry FIFO by
//   writing to KEY_PORT; the consumer reads them, a status byte, and NUM_IN
//   external channels through a registered port_id-decoded input mux.
//
// Ports
//   clk               in   rising-edge clock for all logic
//   reset             in   synchronous, active-high
//   prod_port_id      in   producer port_id
//   prod_out_port     in   producer out_port (push data)
//   prod_write_strobe in   producer write_strobe
//   prod_in_port      out  producer status {0..., overflow, full}, registered
//   cons_port_id      in   consumer port_id; low nibble selects the source
//   cons_read_strobe  in   consumer read_strobe
//   cons_in_port      out  consumer read data, registered
//   ext_in            in   NUM_IN external channels, channel k at [k*DATA_W +: DATA_W]
//
// Flow control: a push is offered when prod_write_strobe is high with
// prod_port_id == KEY_PORT and is accepted unless the FIFO is full with no pop
// in the same cycle (then it is dropped and overflow sets). A pop is offered
// when cons_read_strobe is high with select 0 and is accepted only if the FIFO
// is non-empty (otherwise underflow sets). Both flags are sticky until the
// consumer reads the status select; a set event in the clearing cycle wins.

module pb_key_bridge #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned NUM_IN   = 4,
    parameter logic [7:0]  KEY_PORT = 8'h01
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 prod_port_id,
    input  logic [DATA_W-1:0]          prod_out_port,
    input  logic                       prod_write_strobe,
    output logic [DATA_W-1:0]          prod_in_port,
    input  logic [7:0]                 cons_port_id,
    input  logic                       cons_read_strobe,
    output logic [DATA_W-1:0]          cons_in_port,
    input  logic [NUM_IN*DATA_W-1:0]   ext_in
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [DATA_W-1:0] cons_in_port_q, cons_in_port_d;
    logic [DATA_W-1:0] prod_in_port_q, prod_in_port_d;

    logic [3:0]        sel;
    logic              empty, full;
    logic              push_req, push_ok, pop_req, pop_ok, status_clr;
    logic [3:0]        cnt4;
    logic [DATA_W-1:0] status;
    logic              unused_port_bits;

    // Only the low nibble of the consumer port_id is decoded.
    assign sel              = cons_port_id[3:0];
    assign unused_port_bits = ^cons_port_id[7:4];

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign push_req   = prod_write_strobe && (prod_port_id == KEY_PORT);
    assign pop_req    = cons_read_strobe && (sel == 4'd0);
    assign pop_ok     = pop_req && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok    = push_req && (!full || pop_ok);
    assign status_clr = cons_read_strobe && (sel == 4'd1);

    always_comb begin
        cnt4 = 4'(count_q);
        if (32'(count_q) > 32'd15) begin
            cnt4 = 4'hF;
        end
        status      = '0;
        status[7:0] = {ovf_q, unf_q, empty, full, cnt4};
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Set terms are OR-ed after the clear so a same-cycle event wins.
        ovf_d = (ovf_q && !status_clr) || (push_req && !push_ok);
        unf_d = (unf_q && !status_clr) || (pop_req && empty);

        cons_in_port_d = '0;
        if (sel == 4'd0) begin
            if (!empty) begin
                cons_in_port_d = mem_q[rd_ptr_q];
            end
        end else if (sel == 4'd1) begin
            cons_in_port_d = status;
        end else begin
            for (int k = 0; k < int'(NUM_IN); k++) begin
                if (sel == 4'(k + 2)) begin
                    cons_in_port_d = ext_in[k*DATA_W +: DATA_W];
                end
            end
        end

        prod_in_port_d      = '0;
        prod_in_port_d[1:0] = {ovf_q, full};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            ovf_q          <= 1'b0;
            unf_q          <= 1'b0;
            cons_in_port_q <= '0;
            prod_in_port_q <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            ovf_q          <= ovf_d;
            unf_q          <= unf_d;
            cons_in_port_q <= cons_in_port_d;
            prod_in_port_q <= prod_in_port_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= prod_out_port;
        end
    end

    assign cons_in_port = cons_in_port_q;
    assign prod_in_port = prod_in_port_q;

endmodule

// File: tb/tb_pb_key_bridge.sv
module tb_pb_key_bridge;

    localparam int         DATA_W   = 8;
    localparam int         DEPTH    = 16;
    localparam int         NUM_IN   = 4;
    localparam logic [7:0] KEY_PORT = 8'h01;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [7:0]               prod_port_id = '0;
    logic [DATA_W-1:0]        prod_out_port = '0;
    logic                     prod_write_strobe = 1'b0;
    logic [DATA_W-1:0]        prod_in_port;
    logic [7:0]               cons_port_id = '0;
    logic                     cons_read_strobe = 1'b0;
    logic [DATA_W-1:0]        cons_in_port;
    logic [NUM_IN*DATA_W-1:0] ext_in = '0;

    int checks = 0;
    int errors = 0;

    // scoreboard: expected consumer reads, in issue order
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] mon_exp;

    // reference model: FIFO as a queue plus two sticky flags
    logic [7:0] mq[$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    pb_key_bridge #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_IN(NUM_IN), .KEY_PORT(KEY_PORT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .prod_port_id(prod_port_id),
        .prod_out_port(prod_out_port),
        .prod_write_strobe(prod_write_strobe),
        .prod_in_port(prod_in_port),
        .cons_port_id(cons_port_id),
        .cons_read_strobe(cons_read_strobe),
        .cons_in_port(cons_in_port),
        .ext_in(ext_in)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_status();
        int n;
        logic [3:0] c;
        n = mq.size();
        c = (n > 15) ? 4'd15 : 4'(n);
        return {m_ovf, m_unf, (n == 0), (n == DEPTH), c};
    endfunction

    function automatic logic [7:0] model_read(input logic [3:0] sel);
        if (sel == 4'd0) return (mq.size() > 0) ? mq[0] : 8'h00;
        if (sel == 4'd1) return model_status();
        if (int'(sel) >= 2 && int'(sel) <= NUM_IN + 1) return ext_in[(int'(sel) - 2)*8 +: 8];
        return 8'h00;
    endfunction

    // one clock edge of the model: push = key-port write, rd = read strobe with sel
    function automatic void model_step(input bit push, input logic [7:0] pd,
                                       input bit rd, input logic [3:0] sel);
        bit pop_req;
        bit can_pop;
        pop_req = rd && (sel == 4'd0);
        can_pop = pop_req && (mq.size() > 0);
        if (rd && sel == 4'd1) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (pop_req && !can_pop) m_unf = 1'b1;
        if (push && mq.size() == DEPTH && !can_pop) m_ovf = 1'b1;
        if (can_pop) void'(mq.pop_front());
        if (push && mq.size() < DEPTH) mq.push_back(pd);
    endfunction

    // ---------------- driver tasks (entered just after a rising edge) ----------------
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        chk("reset_cons_in_port", cons_in_port, 8'h00);
        chk("reset_prod_in_port", prod_in_port, 8'h00);
    endtask

    task automatic do_push(input logic [7:0] d, input bit key);
        prod_port_id      = key ? KEY_PORT : 8'($urandom_range(2, 255));
        prod_out_port     = d;
        prod_write_strobe = 1'b1;
        @(posedge clk); #1;
        model_step(key, d, 1'b0, 4'd0);
        prod_write_strobe = 1'b0;
    endtask

    // port_id held two cycles, read_strobe in the second; optional push alongside the strobe
    task automatic do_read(input logic [3:0] sel, input bit with_push, input logic [7:0] pd);
        cons_port_id = {4'($urandom_range(0, 15)), sel};
        exp_q.push_back(model_read(sel));
        @(posedge clk); #1;
        cons_read_strobe = 1'b1;
        if (with_push) begin
            prod_port_id      = KEY_PORT;
            prod_out_port     = pd;
            prod_write_strobe = 1'b1;
        end
        @(posedge clk); #1;
        model_step(with_push, pd, 1'b1, sel);
        cons_read_strobe  = 1'b0;
        prod_write_strobe = 1'b0;
    endtask

    task automatic check_prod();
        @(posedge clk); #1;
        chk("prod_status", prod_in_port, {6'b0, m_ovf, (mq.size() == DEPTH)});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset && cons_read_strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cons_read: strobe with no expectation, got %02h", cons_in_port);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("cons_read", cons_in_port, mon_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        @(posedge clk); #1;

        // T1: basic push/pop order and status
        do_reset();
        do_push(8'hA5, 1'b1);
        do_push(8'h3C, 1'b1);
        do_read(4'd0, 1'b0, 8'h00);
        do_read(4'd0, 1'b0, 8'h00);
        do_read(4'd1, 1'b0, 8'h00);

        // T2: overflow, dropped byte, pointer wrap, clear vs same-cycle overflow
        do_reset();
        for (int i = 0; i <= DEPTH; i++) do_push(8'(i), 1'b1);
        check_prod();
        do_read(4'd1, 1'b1, 8'hEE);
        do_read(4'd1, 1'b0, 8'h00);
        do_read(4'd1, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) do_read(4'd0, 1'b0, 8'h00);
        do_read(4'd1, 1'b0, 8'h00);

        // T3: underflow, status clear, empty + push + pop
        do_read(4'd0, 1'b0, 8'h00);
        do_read(4'd1, 1'b0, 8'h00);
        do_read(4'd1, 1'b0, 8'h00);
        do_read(4'd0, 1'b1, 8'h11);
        do_read(4'd0, 1'b0, 8'h00);
        do_read(4'd1, 1'b0, 8'h00);

        // T4: full + simultaneous push and pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_push(8'(8'h40 + i), 1'b1);
        do_read(4'd0, 1'b1, 8'h77);
        check_prod();
        do_read(4'd1, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) do_read(4'd0, 1'b0, 8'h00);

        // T5: external channels, unmapped select, no side pop
        ext_in = $urandom();
        ext_in[23:16] = 8'h5A;
        do_push(8'h99, 1'b1);
        do_read(4'd4, 1'b0, 8'h00);
        do_read(4'd15, 1'b0, 8'h00);
        do_read(4'd2, 1'b0, 8'h00);
        do_read(4'd0, 1'b0, 8'h00);

        // T6: reset with entries queued
        do_reset();
        for (int i = 0; i < 5; i++) do_push(8'($urandom_range(0, 255)), 1'b1);
        do_reset();
        do_read(4'd1, 1'b0, 8'h00);
        do_push(8'hC3, 1'b1);
        do_read(4'd0, 1'b0, 8'h00);
        do_read(4'd1, 1'b0, 8'h00);

        // random traffic, alternating push-heavy and pop-heavy phases
        for (int i = 0; i < 400; i++) begin
            int op;
            int push_w;
            logic [3:0] s;
            push_w = ((i / 50) % 2 == 0) ? 5 : 1;
            op = $urandom_range(0, 9);
            s = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
            ext_in = $urandom();
            if (op < push_w) begin
                do_push(8'($urandom_range(0, 255)), ($urandom_range(0, 6) != 0));
            end else if (op < 8) begin
                do_read(s, 1'b0, 8'h00);
            end else if (op == 8) begin
                do_read(s, 1'b1, 8'($urandom_range(0, 255)));
            end else begin
                check_prod();
            end
        end

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
